rbm_sequencer: RTL and testbench
================================

// Module: rbm_sequencer
// PURPOSE
//  Hardware sequencer for the Main RBM datapath, replacing the bench-side state machine.
//  Each iteration streams pixel/weight addresses for every hidden unit (data terms, then bias)
//  and latches each sampled hidden bit into an internal buffer.
//  It then streams hidden bits and classifier addresses for every class and accumulates spike counts.
//  After ITER_NUM iterations it reports the class with the most spikes (argmax).
// PARAMETERS
//  N_PIXEL   784  visible inputs per hidden unit
//  N_HIDDEN  441  hidden units
//  N_CLASS   10   classifier outputs
//  ITER_NUM  100  iterations per run (>=1)
//  CNT_W     8    spike counter width; counters saturate at 2^CNT_W-1
//  PW        10   pixel_addr width; must hold N_PIXEL
//  HW        9    hidden_addr width; must hold N_HIDDEN
//  CW        4    class_addr / winner width; must hold N_CLASS
// PORTS
//  clock          in   1      rising-edge clock (single clock domain)
//  reset          in   1      asynchronous, active-high; clears all state
//  start          in   1      run request; accepted only in IDLE
//  abort          in   1      synchronous; returns to IDLE on the next edge, no done pulse
//  hidden         in   1      sampled hidden bit from Main; valid during H_CAP
//  spike          in   1      spike bit from Main; valid during C_CAP
//  pixel_addr     out  PW     InputData/HiddenWeight row index; N_PIXEL during the hidden-bias cycle
//  hidden_addr    out  HW     current hidden unit (H phase) or hidden term (C phase)
//  class_addr     out  CW     current class
//  h_bias_sel     out  1      1 = external mux drives pixel=1, Hvalue=HiddenBias[hidden_addr]
//  c_bias_sel     out  1      1 = external mux drives Cvalue=ClassiBias[class_addr]
//  enable_hidden  out  1      to Main
//  enable_classi  out  1      to Main
//  unit_clr       out  1      1-cycle pulse on the first cycle of each hidden/class accumulation
//  hidden_pixel   out  1      buffer[hidden_addr] in C_RUN data cycles; 1 in the C bias cycle; else 0
//  busy           out  1      high in every state except IDLE
//  done           out  1      1-cycle pulse; winner and counts are valid from this cycle until the next start
//  winner         out  CW     argmax of the spike counts; ties resolve to the lowest index
//  cnt_rd_addr    in   CW     spike-count read address
//  cnt_rd_data    out  CNT_W  combinational read of count[cnt_rd_addr]
// BEHAVIOUR
//  Reset values: every output 0; counts, hidden buffer and winner cleared; state IDLE.
//  States: IDLE -> H_RUN -> H_CAP -> (H_RUN | C_RUN) -> C_CAP -> (C_RUN | H_RUN | ARGMAX)
//          -> DONE -> IDLE.
//  IDLE: on start, clear counts and winner, zero all indices, enter H_RUN.
//  H_RUN: enable_hidden=1. Cycles k=0..N_PIXEL-1 drive pixel_addr=k.
//         Cycle k=N_PIXEL drives pixel_addr=N_PIXEL and h_bias_sel=1. unit_clr=1 at k=0.
//  H_CAP: one cycle, enable_hidden=0; buffer[hidden_addr] <= hidden at the end of the cycle.
//         Next: if hidden_addr<N_HIDDEN-1, increment hidden_addr and return to H_RUN;
//         else hidden_addr=0 and enter C_RUN.
//  C_RUN: enable_classi=1. Cycles j=0..N_HIDDEN-1 drive hidden_addr=j.
//         Cycle j=N_HIDDEN drives c_bias_sel=1 and hidden_pixel=1. unit_clr=1 at j=0.
//  C_CAP: one cycle, enable_classi=0; count[class_addr] += spike, saturating.
//         Next: if class_addr<N_CLASS-1, go to the next class in C_RUN.
//         Else increment the iteration count: if it is below ITER_NUM, go to H_RUN with all indices 0;
//         otherwise go to ARGMAX.
//  enable_hidden and enable_classi are never high together.
//  Cycles per iteration: P = N_HIDDEN*(N_PIXEL+2) + N_CLASS*(N_HIDDEN+2).
//  ARGMAX: N_CLASS cycles, one compare per cycle; a strictly greater count replaces the best.
//  DONE: one cycle with done=1, then IDLE. The first H_RUN cycle is index 0; done is at index ITER_NUM*P+N_CLASS.
//  start while busy: ignored. start and abort in the same cycle while in IDLE: abort wins, stay IDLE.
//  abort: outputs drop to 0 on the next cycle; counts keep partial values until the next start.
//  Mid-run reset: immediate async clear; no done pulse.
//  Buffer contents are overwritten each iteration, so hidden samples are never reused across iterations.
// TESTING
//  T1 small config (N_PIXEL=4, N_HIDDEN=3, N_CLASS=2, ITER_NUM=2), hidden=1, spike=1 ->
//     P=28; done at cycle 58; counts {2,2}; winner=0.
//  T2 same config, spike=1 only while class_addr=1 -> counts {0,2}; winner=1.
//  T3 address trace, iteration 1: pixel_addr 0,1,2,3,4(h_bias_sel) then H_CAP, repeated per unit;
//     hidden_addr steps 0..2; enable_hidden/enable_classi never both 1.
//  T4 hidden=1 only for unit 1 -> C_RUN hidden_pixel sequence 0,1,0,1(bias) for each class.
//  T5 CNT_W=1, ITER_NUM=3, spike=1 -> counts saturate at 1; winner=0.
//  T6 reset asserted at cycle 10 and abort at cycle 12 of a second run ->
//     all outputs 0 immediately on reset, no done; a fresh start completes exactly as T1.

Source files
------------

// File: rtl/rbm_sequencer_if.sv
// rtl/rbm_sequencer_if.sv - address/strobe bundle between the RBM sequencer and the Main datapath
interface rbm_sequencer_if #(
    parameter int PW = 10,
    parameter int HW = 9,
    parameter int CW = 4
);
    logic [PW-1:0] pixel_addr;
    logic [HW-1:0] hidden_addr;
    logic [CW-1:0] class_addr;
    logic          h_bias_sel;
    logic          c_bias_sel;
    logic          enable_hidden;
    logic          enable_classi;
    logic          unit_clr;
    logic          hidden_pixel;
    logic          hidden;
    logic          spike;

    modport master (
        output pixel_addr, hidden_addr, class_addr, h_bias_sel, c_bias_sel,
               enable_hidden, enable_classi, unit_clr, hidden_pixel,
        input  hidden, spike
    );

    modport slave (
        input  pixel_addr, hidden_addr, class_addr, h_bias_sel, c_bias_sel,
               enable_hidden, enable_classi, unit_clr, hidden_pixel,
        output hidden, spike
    );
endinterface

// File: rtl/rbm_sequencer.sv
// rtl/rbm_sequencer.sv - iteration sequencer for the Main RBM datapath with spike counting and argmax
module rbm_sequencer #(
    parameter int N_PIXEL  = 784,
    parameter int N_HIDDEN = 441,
    parameter int N_CLASS  = 10,
    parameter int ITER_NUM = 100,
    parameter int CNT_W    = 8,
    parameter int PW       = 10,
    parameter int HW       = 9,
    parameter int CW       = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    rbm_sequencer_if.master  bus,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    winner,
    input  logic [CW-1:0]    cnt_rd_addr,
    output logic [CNT_W-1:0] cnt_rd_data
);
    localparam int IW = $clog2(ITER_NUM + 1);

    typedef enum logic [2:0] {
        IDLE, H_RUN, H_CAP, C_RUN, C_CAP, ARGMAX, DONE
    } state_t;

    state_t              state;
    logic [PW-1:0]       pix;
    logic [HW-1:0]       hid;
    logic [CW-1:0]       cls;
    logic [CW-1:0]       am_idx;
    logic [IW-1:0]       iter;
    logic                en_h, en_c, h_bias, c_bias, uclr;
    logic [N_HIDDEN-1:0] hbuf;
    logic [CNT_W-1:0]    count [N_CLASS];
    logic [CNT_W-1:0]    best;
    logic [CNT_W-1:0]    cls_cnt;
    logic [CNT_W-1:0]    am_cnt;
    logic                buf_bit;

    // Compare-based selects keep every index in range, including the bias cycle where hid == N_HIDDEN.
    always_comb begin
        buf_bit     = 1'b0;
        cls_cnt     = '0;
        am_cnt      = '0;
        cnt_rd_data = '0;
        for (int i = 0; i < N_HIDDEN; i++) begin
            if (hid == HW'(i)) buf_bit = hbuf[i];
        end
        for (int i = 0; i < N_CLASS; i++) begin
            if (cls == CW'(i))         cls_cnt     = count[i];
            if (am_idx == CW'(i))      am_cnt      = count[i];
            if (cnt_rd_addr == CW'(i)) cnt_rd_data = count[i];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            pix    <= '0;
            hid    <= '0;
            cls    <= '0;
            am_idx <= '0;
            iter   <= '0;
            en_h   <= 1'b0;
            en_c   <= 1'b0;
            h_bias <= 1'b0;
            c_bias <= 1'b0;
            uclr   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            winner <= '0;
            best   <= '0;
            hbuf   <= '0;
            for (int i = 0; i < N_CLASS; i++) count[i] <= '0;
        end else if (abort) begin
            state  <= IDLE;
            pix    <= '0;
            hid    <= '0;
            cls    <= '0;
            am_idx <= '0;
            iter   <= '0;
            en_h   <= 1'b0;
            en_c   <= 1'b0;
            h_bias <= 1'b0;
            c_bias <= 1'b0;
            uclr   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N_CLASS; i++) count[i] <= '0;
                        winner <= '0;
                        pix    <= '0;
                        hid    <= '0;
                        cls    <= '0;
                        iter   <= '0;
                        en_h   <= 1'b1;
                        uclr   <= 1'b1;
                        busy   <= 1'b1;
                        state  <= H_RUN;
                    end
                end
                H_RUN: begin
                    uclr <= 1'b0;
                    if (pix == PW'(N_PIXEL)) begin
                        en_h   <= 1'b0;
                        h_bias <= 1'b0;
                        pix    <= '0;
                        state  <= H_CAP;
                    end else begin
                        pix    <= pix + PW'(1);
                        h_bias <= (pix == PW'(N_PIXEL - 1));
                    end
                end
                H_CAP: begin
                    for (int i = 0; i < N_HIDDEN; i++) begin
                        if (hid == HW'(i)) hbuf[i] <= bus.hidden;
                    end
                    uclr <= 1'b1;
                    if (hid < HW'(N_HIDDEN - 1)) begin
                        hid   <= hid + HW'(1);
                        en_h  <= 1'b1;
                        state <= H_RUN;
                    end else begin
                        hid   <= '0;
                        en_c  <= 1'b1;
                        state <= C_RUN;
                    end
                end
                C_RUN: begin
                    uclr <= 1'b0;
                    if (hid == HW'(N_HIDDEN)) begin
                        en_c   <= 1'b0;
                        c_bias <= 1'b0;
                        hid    <= '0;
                        state  <= C_CAP;
                    end else begin
                        hid    <= hid + HW'(1);
                        c_bias <= (hid == HW'(N_HIDDEN - 1));
                    end
                end
                C_CAP: begin
                    for (int i = 0; i < N_CLASS; i++) begin
                        if (cls == CW'(i) && bus.spike && cls_cnt != '1) count[i] <= cls_cnt + CNT_W'(1);
                    end
                    if (cls < CW'(N_CLASS - 1)) begin
                        cls   <= cls + CW'(1);
                        en_c  <= 1'b1;
                        uclr  <= 1'b1;
                        state <= C_RUN;
                    end else begin
                        cls <= '0;
                        if (iter < IW'(ITER_NUM - 1)) begin
                            iter  <= iter + IW'(1);
                            en_h  <= 1'b1;
                            uclr  <= 1'b1;
                            state <= H_RUN;
                        end else begin
                            am_idx <= '0;
                            best   <= '0;
                            winner <= '0;
                            state  <= ARGMAX;
                        end
                    end
                end
                ARGMAX: begin
                    // Strict compare: on ties the earlier (lower) class keeps the win.
                    if (am_cnt > best) begin
                        best   <= am_cnt;
                        winner <= am_idx;
                    end
                    if (am_idx == CW'(N_CLASS - 1)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        am_idx <= am_idx + CW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pixel_addr    = pix;
    assign bus.hidden_addr   = hid;
    assign bus.class_addr    = cls;
    assign bus.h_bias_sel    = h_bias;
    assign bus.c_bias_sel    = c_bias;
    assign bus.enable_hidden = en_h;
    assign bus.enable_classi = en_c;
    assign bus.unit_clr      = uclr;
    assign bus.hidden_pixel  = en_c & (c_bias | buf_bit);
endmodule

// File: tb/tb_rbm_sequencer.sv
// tb/tb_rbm_sequencer.sv - randomized self-checking bench for rbm_sequencer against a schedule model
module tb_rbm_sequencer;
    localparam int NP = 4, NH = 3, NC = 2, NI = 2;
    localparam int BNP = 2, BNH = 2, BNC = 3, BNI = 3;
    localparam int PB = BNH * (BNP + 2) + BNC * (BNH + 2);

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0, abort = 1'b0;
    logic       busy_a, done_a, busy_b, done_b;
    logic [1:0] winner_a, winner_b;
    logic [1:0] rd_a = '0, rd_b = '0;
    logic [7:0] rdata_a;
    logic [0:0] rdata_b;
    int         n_chk = 0, n_fail = 0;

    rbm_sequencer_if #(.PW(3), .HW(2), .CW(2)) bus_a ();
    rbm_sequencer_if #(.PW(2), .HW(2), .CW(2)) bus_b ();

    rbm_sequencer #(.N_PIXEL(NP), .N_HIDDEN(NH), .N_CLASS(NC), .ITER_NUM(NI), .CNT_W(8),
                    .PW(3), .HW(2), .CW(2)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .abort(abort), .bus(bus_a),
        .busy(busy_a), .done(done_a), .winner(winner_a), .cnt_rd_addr(rd_a), .cnt_rd_data(rdata_a));

    rbm_sequencer #(.N_PIXEL(BNP), .N_HIDDEN(BNH), .N_CLASS(BNC), .ITER_NUM(BNI), .CNT_W(1),
                    .PW(2), .HW(2), .CW(2)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .abort(abort), .bus(bus_b),
        .busy(busy_b), .done(done_b), .winner(winner_b), .cnt_rd_addr(rd_b), .cnt_rd_data(rdata_b));

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] strobes_a();
        return {bus_a.enable_hidden, bus_a.enable_classi, bus_a.h_bias_sel, bus_a.c_bias_sel,
                bus_a.unit_clr, bus_a.hidden_pixel, busy_a, done_a};
    endfunction

    function automatic logic [7:0] sv(input bit eh, ec, hb, cb, uc, hp, bz, dn);
        return {eh, ec, hb, cb, uc, hp, bz, dn};
    endfunction

    // Stimulus per mode: 1 = all ones, 2 = spike only for class 1, 3 = hidden only for unit 1, else random.
    function automatic bit hval(input int mode, input int u);
        if (mode == 1) return 1'b1;
        if (mode == 3) return (u == 1);
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit sval(input int mode, input int c);
        if (mode == 1) return 1'b1;
        if (mode == 2) return (c == 1);
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic step_a(input string tag, input logic [7:0] es, input int pix, input int hid,
                          input int cls, input bit h, input bit s);
        check_eq({tag, " strobes"}, strobes_a(), es);
        if (pix >= 0) check_eq({tag, " pixel_addr"}, bus_a.pixel_addr, pix);
        if (hid >= 0) check_eq({tag, " hidden_addr"}, bus_a.hidden_addr, hid);
        if (cls >= 0) check_eq({tag, " class_addr"}, bus_a.class_addr, cls);
        bus_a.hidden = h;
        bus_a.spike  = s;
        start_a      = 1'($urandom_range(0, 1));
        @(posedge clock); #1;
    endtask

    task automatic run_a(input int mode);
        int cnt[NC];
        bit hb[NH];
        bit h, s;
        int best;
        foreach (cnt[i]) cnt[i] = 0;
        start_a = 1'b1;
        @(posedge clock); #1;
        for (int it = 0; it < NI; it++) begin
            for (int u = 0; u < NH; u++) begin
                for (int k = 0; k <= NP; k++)
                    step_a("h_run", sv(1, 0, k == NP, 0, k == 0, 0, 1, 0), k, u, 0, hval(mode, u), sval(mode, -1));
                h = hval(mode, u);
                hb[u] = h;
                step_a("h_cap", sv(0, 0, 0, 0, 0, 0, 1, 0), -1, u, 0, h, sval(mode, -1));
            end
            for (int c = 0; c < NC; c++) begin
                for (int j = 0; j <= NH; j++)
                    step_a("c_run", sv(0, 1, 0, j == NH, j == 0, (j < NH) ? hb[j] : 1'b1, 1, 0),
                           -1, (j < NH) ? j : -1, c, hval(mode, -1), sval(mode, c));
                s = sval(mode, c);
                if (s && cnt[c] < 255) cnt[c]++;
                step_a("c_cap", sv(0, 0, 0, 0, 0, 0, 1, 0), -1, -1, c, hval(mode, -1), s);
            end
        end
        for (int a = 0; a < NC; a++)
            step_a("argmax", sv(0, 0, 0, 0, 0, 0, 1, 0), -1, -1, -1, 1'b0, 1'b0);
        best = 0;
        for (int i = 1; i < NC; i++) if (cnt[i] > cnt[best]) best = i;
        check_eq("done strobes", strobes_a(), sv(0, 0, 0, 0, 0, 0, 1, 1));
        check_eq("winner", winner_a, best);
        for (int i = 0; i < NC; i++) begin
            rd_a = 2'(i);
            #1;
            check_eq("count", rdata_a, cnt[i]);
        end
        start_a = 1'b0;
        @(posedge clock); #1;
        check_eq("idle after done", strobes_a(), 8'h00);
        check_eq("winner held", winner_a, best);
    endtask

    task automatic check_quiet_a(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            check_eq(tag, {strobes_a(), 3'(bus_a.pixel_addr), bus_a.hidden_addr, bus_a.class_addr}, '0);
            @(posedge clock); #1;
        end
    endtask

    task automatic reset_abort_test();
        start_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check_quiet_a("async reset", 1);
        reset = 1'b0;
        check_quiet_a("after reset", 4);
        start_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        check_quiet_a("after abort", 6);
        start_a = 1'b1;
        abort   = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
        abort   = 1'b0;
        check_quiet_a("start with abort", 3);
    endtask

    task automatic run_b(input int mode);
        int cyc = 0;
        int exp_cnt[BNC];
        int best = 0;
        start_b = 1'b1;
        @(posedge clock); #1;
        start_b = 1'b0;
        while (!done_b && cyc < 500) begin
            bus_b.hidden = 1'($urandom_range(0, 1));
            bus_b.spike  = (mode == 0) ? 1'b1 : (bus_b.class_addr == 2'd2);
            @(posedge clock); #1;
            cyc++;
        end
        check_eq("b done cycle", cyc, BNI * PB + BNC);
        for (int c = 0; c < BNC; c++) begin
            exp_cnt[c] = (mode == 0 || c == 2) ? BNI : 0;
            if (exp_cnt[c] > 1) exp_cnt[c] = 1;
            if (exp_cnt[c] > exp_cnt[best]) best = c;
            rd_b = 2'(c);
            #1;
            check_eq("b saturated count", rdata_b, exp_cnt[c]);
        end
        check_eq("b winner", winner_b, best);
        @(posedge clock); #1;
        check_eq("b idle", {busy_b, done_b}, 2'b00);
    endtask

    initial begin
        bus_a.hidden = 1'b0;
        bus_a.spike  = 1'b0;
        bus_b.hidden = 1'b0;
        bus_b.spike  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_quiet_a("reset state", 1);
        check_eq("reset done/busy/winner", {busy_a, done_a, winner_a, rdata_a}, '0);
        check_eq("reset b", {busy_b, done_b, winner_b, rdata_b}, '0);
        reset = 1'b0;
        @(posedge clock); #1;
        run_a(1);
        run_a(2);
        run_a(3);
        for (int r = 0; r < 4; r++) run_a(0);
        reset_abort_test();
        run_a(1);
        run_b(0);
        run_b(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
